// File: rtl/ysyx_23060240_wb_pkg.sv
// Shared encodings for the write-back unit: result-select codes, FSM states, default reset PC.
package ysyx_23060240_wb_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB      = 2'd1,
    S_HANDOFF = 2'd2,
    S_HALT    = 2'd3
  } wb_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060240_wb_mux.sv
// Combinational write-back result select; the link value is pc+4, wrapping modulo 2^32.
module ysyx_23060240_wb_mux
  import ysyx_23060240_wb_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] csr_rdata_i,
  output logic [31:0] wdata_o
);

  logic [31:0] pc4;

  assign pc4 = pc_i + 32'd4;

  always_comb begin
    wdata_o = alu_res_i;
    unique case (sel_i)
      WB_ALU:  wdata_o = alu_res_i;
      WB_MEM:  wdata_o = mem_data_i;
      WB_PC4:  wdata_o = pc4;
      WB_CSR:  wdata_o = csr_rdata_i;
      default: wdata_o = alu_res_i;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_wbu.sv
// Write-back unit: captures one LSU result, writes the register file once, hands dnpc to the IFU.
// Keeps a retired-instruction counter, a sticky halt on ebreak and a sticky protocol-error flag.
module ysyx_23060240_wbu
  import ysyx_23060240_wb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_dnpc,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wen,
  input  logic [1:0]       in_wb_sel,
  input  logic [31:0]      in_alu_res,
  input  logic [31:0]      in_mem_data,
  input  logic [31:0]      in_csr_rdata,
  input  logic             in_ebreak,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             ifu_valid,
  input  logic             ifu_ready,
  output logic [31:0]      next_pc,
  output logic [CNT_W-1:0] retired,
  output logic             halt,
  output logic             proto_err
);

  wb_state_e        state_q;
  logic             rf_wen_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;
  logic [31:0]      dnpc_q;
  logic             ebreak_q;
  logic [31:0]      next_pc_q;
  logic [CNT_W-1:0] retired_q;
  logic             halt_q;
  logic             proto_err_q;
  logic [31:0]      wdata_d;

  ysyx_23060240_wb_mux u_mux (
    .sel_i       (in_wb_sel),
    .pc_i        (in_pc),
    .alu_res_i   (in_alu_res),
    .mem_data_i  (in_mem_data),
    .csr_rdata_i (in_csr_rdata),
    .wdata_o     (wdata_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      dnpc_q      <= RESET_PC;
      ebreak_q    <= 1'b0;
      next_pc_q   <= RESET_PC;
      retired_q   <= '0;
      halt_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rf_wen_q <= 1'b0;
      if (lsu_valid && (state_q != S_IDLE)) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (lsu_valid) begin
            // rf_wen is registered here so it is high for exactly the WB cycle
            rf_wen_q   <= in_rd_wen && (in_rd != 5'd0);
            rf_waddr_q <= in_rd;
            rf_wdata_q <= wdata_d;
            dnpc_q     <= in_dnpc;
            ebreak_q   <= in_ebreak;
            state_q    <= S_WB;
          end
        end
        S_WB: begin
          // next_pc only moves on entry to HANDOFF so it holds the last handed-off PC elsewhere
          next_pc_q <= dnpc_q;
          state_q   <= S_HANDOFF;
        end
        S_HANDOFF: begin
          if (ifu_ready) begin
            retired_q <= retired_q + CNT_W'(1);
            if (ebreak_q) begin
              halt_q  <= 1'b1;
              state_q <= S_HALT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lsu_ready = (state_q == S_IDLE);
  assign ifu_valid = (state_q == S_HANDOFF);
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign next_pc   = next_pc_q;
  assign retired   = retired_q;
  assign halt      = halt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ysyx_23060240_wbu.sv
// Self-checking bench for ysyx_23060240_wbu: directed cases plus randomized instructions vs a transaction model.
module tb_ysyx_23060240_wbu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [31:0] in_pc;
  logic [31:0] in_dnpc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_res;
  logic [31:0] in_mem_data;
  logic [31:0] in_csr_rdata;
  logic        in_ebreak;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] next_pc;
  logic [63:0] retired;
  logic        halt;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  logic [63:0] m_retired;
  logic        m_proto;
  logic [31:0] m_npc;

  ysyx_23060240_wbu #(.RESET_PC(RST_PC), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .in_pc        (in_pc),
    .in_dnpc      (in_dnpc),
    .in_rd        (in_rd),
    .in_rd_wen    (in_rd_wen),
    .in_wb_sel    (in_wb_sel),
    .in_alu_res   (in_alu_res),
    .in_mem_data  (in_mem_data),
    .in_csr_rdata (in_csr_rdata),
    .in_ebreak    (in_ebreak),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .ifu_valid    (ifu_valid),
    .ifu_ready    (ifu_ready),
    .next_pc      (next_pc),
    .retired      (retired),
    .halt         (halt),
    .proto_err    (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_wdata(input logic [1:0] sel, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [31:0] mem,
                                            input logic [31:0] csr);
    logic [32:0] link;
    link = {1'b0, pc} + 33'd4;
    case (sel)
      2'd0:    return alu;
      2'd1:    return mem;
      2'd2:    return link[31:0];
      default: return csr;
    endcase
  endfunction

  task automatic scramble();
    in_pc        = $urandom;
    in_dnpc      = $urandom;
    in_rd        = 5'($urandom);
    in_rd_wen    = 1'($urandom);
    in_wb_sel    = 2'($urandom);
    in_alu_res   = $urandom;
    in_mem_data  = $urandom;
    in_csr_rdata = $urandom;
    in_ebreak    = 1'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   64'(lsu_ready), 64'd1);
    chk({tag, "_wen"},   64'(rf_wen), 64'd0);
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, "_ifuv"},  64'(ifu_valid), 64'd0);
    chk({tag, "_npc"},   64'(next_pc), 64'(RST_PC));
    chk({tag, "_ret"},   retired, 64'd0);
    chk({tag, "_halt"},  64'(halt), 64'd0);
    chk({tag, "_perr"},  64'(proto_err), 64'd0);
  endtask

  // Called at a negedge; rst is sampled at the next posedge, values checked on the following negedge.
  task automatic do_reset();
    rst       = 1'b1;
    lsu_valid = 1'b0;
    ifu_ready = 1'b0;
    scramble();
    @(negedge clk);
    check_reset_vals("rst");
    rst       = 1'b0;
    m_retired = 64'd0;
    m_proto   = 1'b0;
    m_npc     = RST_PC;
  endtask

  // Called at a negedge while IDLE is expected; returns at the negedge right after the handoff edge.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] dnpc, input logic [4:0] rd,
                           input logic rd_wen, input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [31:0] csr, input logic ebrk,
                           input int stall, input bit poke);
    logic [31:0] exp_wd;
    logic        exp_wen;
    exp_wd  = ref_wdata(sel, pc, alu, mem, csr);
    exp_wen = rd_wen && (rd != 5'd0);

    chk("idle_rdy", 64'(lsu_ready), 64'd1);
    chk("idle_npc", 64'(next_pc), 64'(m_npc));
    in_pc = pc; in_dnpc = dnpc; in_rd = rd; in_rd_wen = rd_wen; in_wb_sel = sel;
    in_alu_res = alu; in_mem_data = mem; in_csr_rdata = csr; in_ebreak = ebrk;
    lsu_valid = 1'b1;
    ifu_ready = 1'($urandom);

    @(negedge clk);
    lsu_valid = 1'b0;
    scramble();
    chk("wb_wen", 64'(rf_wen), 64'(exp_wen));
    if (exp_wen) begin
      chk("wb_waddr", 64'(rf_waddr), 64'(rd));
      chk("wb_wdata", 64'(rf_wdata), 64'(exp_wd));
    end
    chk("wb_ifuv", 64'(ifu_valid), 64'd0);
    chk("wb_rdy", 64'(lsu_ready), 64'd0);
    chk("wb_npc", 64'(next_pc), 64'(m_npc));
    // an early ifu_ready in WB must not cut HANDOFF short
    ifu_ready = 1'($urandom);

    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      lsu_valid = 1'b0;
      chk("ho_ifuv", 64'(ifu_valid), 64'd1);
      chk("ho_npc", 64'(next_pc), 64'(dnpc));
      chk("ho_wen", 64'(rf_wen), 64'd0);
      chk("ho_rdy", 64'(lsu_ready), 64'd0);
      chk("ho_ret", retired, m_retired);
      chk("ho_perr", 64'(proto_err), 64'(m_proto));
      ifu_ready = (i == stall);
      if (poke && i == 0) begin
        lsu_valid = 1'b1;
        m_proto   = 1'b1;
      end
    end

    @(negedge clk);
    lsu_valid = 1'b0;
    ifu_ready = 1'b0;
    m_retired = m_retired + 64'd1;
    m_npc     = dnpc;
    chk("post_ret", retired, m_retired);
    chk("post_halt", 64'(halt), 64'(ebrk));
    chk("post_rdy", 64'(lsu_ready), 64'(!ebrk));
    chk("post_ifuv", 64'(ifu_valid), 64'd0);
    chk("post_npc", 64'(next_pc), 64'(m_npc));
    chk("post_perr", 64'(proto_err), 64'(m_proto));
  endtask

  initial begin
    rst = 1'b0; lsu_valid = 1'b0; ifu_ready = 1'b0;
    scramble();
    m_retired = 64'd0; m_proto = 1'b0; m_npc = RST_PC;
    @(negedge clk);
    do_reset();

    // ALU result to x5
    run_instr(32'h8000_0000, 32'h8000_0004, 5'd5, 1'b1, 2'b00, 32'h0000_1234,
              32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    // load into x0: no write, handoff still happens
    run_instr(32'h8000_0004, 32'h8000_0008, 5'd0, 1'b1, 2'b01, 32'h1111_1111,
              32'h5555_AAAA, 32'h2222_2222, 1'b0, 0, 1'b0);
    // link at the top of the address space wraps to zero
    run_instr(32'hFFFF_FFFC, 32'h8000_0100, 5'd1, 1'b1, 2'b10, 32'h3333_3333,
              32'h4444_4444, 32'h6666_6666, 1'b0, 1, 1'b0);
    // CSR read with rd_wen low
    run_instr(32'h8000_0100, 32'h8000_0104, 5'd9, 1'b0, 2'b11, 32'h7777_7777,
              32'h8888_8888, 32'h0000_1800, 1'b0, 0, 1'b0);
    // backpressure for 4 cycles with a stray lsu_valid
    run_instr(32'h8000_0104, 32'h8000_0200, 5'd12, 1'b1, 2'b11, 32'h0,
              32'h0, 32'hABCD_0123, 1'b0, 4, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      run_instr($urandom, $urandom, rd, 1'($urandom), 2'($urandom), $urandom,
                $urandom, $urandom, 1'b0, int'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0));
    end

    // ebreak retires and the unit parks in HALT
    run_instr(32'h8000_0300, 32'h8000_0304, 5'd10, 1'b1, 2'b00, 32'h0000_0042,
              32'h0, 32'h0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1;
      ifu_ready = 1'b1;
      scramble();
      m_proto = 1'b1;
      @(negedge clk);
      chk("halt_flag", 64'(halt), 64'd1);
      chk("halt_rdy", 64'(lsu_ready), 64'd0);
      chk("halt_ifuv", 64'(ifu_valid), 64'd0);
      chk("halt_wen", 64'(rf_wen), 64'd0);
      chk("halt_ret", retired, m_retired);
      chk("halt_perr", 64'(proto_err), 64'(m_proto));
    end
    lsu_valid = 1'b0;
    ifu_ready = 1'b0;
    do_reset();

    // reset while a write is pending in WB
    in_pc = 32'h8000_0000; in_dnpc = 32'h8000_0040; in_rd = 5'd7; in_rd_wen = 1'b1;
    in_wb_sel = 2'b00; in_alu_res = 32'h0BAD_F00D; in_ebreak = 1'b0;
    lsu_valid = 1'b1;
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("rwb_wen", 64'(rf_wen), 64'd1);
    rst = 1'b1;
    ifu_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifu_ready = 1'b0;
    check_reset_vals("rwb");
    m_retired = 64'd0; m_proto = 1'b0; m_npc = RST_PC;

    // reset coinciding with the handoff handshake wins
    run_instr(32'h8000_0000, 32'h8000_0010, 5'd3, 1'b1, 2'b01, 32'h0,
              32'h1234_5678, 32'h0, 1'b0, 0, 1'b0);
    in_pc = 32'h8000_0010; in_dnpc = 32'h8000_0020; in_rd = 5'd4; in_rd_wen = 1'b1;
    in_wb_sel = 2'b00; in_alu_res = 32'h0000_0099; in_ebreak = 1'b1;
    lsu_valid = 1'b1;
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("rho_ifuv", 64'(ifu_valid), 64'd1);
    rst = 1'b1;
    ifu_ready = 1'b1;
    lsu_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifu_ready = 1'b0;
    lsu_valid = 1'b0;
    check_reset_vals("rho");
    @(negedge clk);
    chk("rho_idle_ifuv", 64'(ifu_valid), 64'd0);
    chk("rho_idle_wen", 64'(rf_wen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
